// File: rtl/pll_supervisor.sv
// Reset, lock-qualification and staggered clock-enable sequencer for an altpll instance.
// Runs on the PLL reference clock; retries on lock timeout or loss, faults once retries run out.
module pll_supervisor #(
    parameter int unsigned NCLK         = 3,
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_CYCLES  = 256,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned ENA_STAGGER  = 8,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic            i_clk,
    input  logic            i_areset_n,
    input  logic            i_pll_locked,
    input  logic            i_restart,
    output logic            o_pll_areset,
    output logic [NCLK-1:0] o_clkena,
    output logic            o_ready,
    output logic            o_fault,
    output logic [((MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1)-1:0] o_retries
);

    localparam int unsigned RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned LAST_EN = (NCLK - 1) * ENA_STAGGER;
    localparam int unsigned MAX_AB  = (RESET_CYCLES > LOCK_CYCLES) ? RESET_CYCLES : LOCK_CYCLES;
    localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > LAST_EN + 1) ? LOCK_TIMEOUT : LAST_EN + 1;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_FILTER,
        ST_ENABLE,
        ST_RUN,
        ST_FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        sync_q, sync_d;
    logic [RW-1:0]     retries_q, retries_d;
    logic              areset_q, areset_d;
    logic [NCLK-1:0]   clkena_q, clkena_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    logic              lck;
    logic              retry;

    assign lck = sync_q[1];

    // Next state, shared counter and registered outputs; outputs follow the next state
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        sync_d    = {sync_q[0], i_pll_locked};
        retries_d = retries_q;
        retry     = 1'b0;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == CW'(RESET_CYCLES - 1)) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lck) state_d = ST_FILTER;
                else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) retry = 1'b1;
            end
            ST_FILTER: begin
                if (!lck) state_d = ST_WAIT_LOCK;
                else if (cnt_q == CW'(LOCK_CYCLES - 1)) state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (!lck) retry = 1'b1;
                else if (cnt_q == CW'(LAST_EN)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lck) retry = 1'b1;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: state_d = ST_RESET;
        endcase

        if (retry) begin
            if (retries_q == RW'(MAX_RETRIES)) begin
                state_d = ST_FAULT;
            end else begin
                retries_d = retries_q + RW'(1);
                state_d   = ST_RESET;
            end
        end

        if (state_d == ST_RUN) retries_d = '0;

        // Counter only runs in timed states; RUN and FAULT park it at zero
        if ((state_d != state_q) || (state_d == ST_RUN) || (state_d == ST_FAULT)) cnt_d = '0;

        if (i_restart) begin
            state_d   = ST_RESET;
            retries_d = '0;
            cnt_d     = '0;
        end

        areset_d = (state_d == ST_RESET) || (state_d == ST_FAULT);
        ready_d  = (state_d == ST_RUN);
        fault_d  = (state_d == ST_FAULT);

        clkena_d = '0;
        if (state_d == ST_RUN) begin
            clkena_d = clkena_q;
        end else if (state_d == ST_ENABLE) begin
            clkena_d = clkena_q;
            for (int unsigned k = 0; k < NCLK; k++) begin
                if (cnt_d == CW'(k * ENA_STAGGER)) clkena_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            sync_q    <= '0;
            retries_q <= '0;
            areset_q  <= 1'b1;
            clkena_q  <= '0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync_q    <= sync_d;
            retries_q <= retries_d;
            areset_q  <= areset_d;
            clkena_q  <= clkena_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign o_pll_areset = areset_q;
    assign o_clkena     = clkena_q;
    assign o_ready      = ready_q;
    assign o_fault      = fault_q;
    assign o_retries    = retries_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed scenario checkpoints plus a randomized lock waveform,
// with every cycle compared against an elapsed-time phase model of the sequencer.
module tb_pll_supervisor;

    localparam int NCLK         = 3;
    localparam int RESET_CYCLES = 8;
    localparam int LOCK_CYCLES  = 16;
    localparam int LOCK_TIMEOUT = 64;
    localparam int ENA_STAGGER  = 4;
    localparam int MAX_RETRIES  = 2;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_FILT  = 2;
    localparam int PH_EN    = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_FAULT = 5;

    logic            clk;
    logic            rst_n;
    logic            locked;
    logic            restart;
    logic            areset;
    logic [NCLK-1:0] clkena;
    logic            ready;
    logic            fault;
    logic [1:0]      retries;

    int n_vec;
    int n_err;
    int cyc;

    int m_phase;
    int m_entry;
    int m_retries;
    bit m_s0;
    bit m_s1;

    pll_supervisor #(
        .NCLK        (NCLK),
        .RESET_CYCLES(RESET_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .ENA_STAGGER (ENA_STAGGER),
        .MAX_RETRIES (MAX_RETRIES)
    ) dut (
        .i_clk       (clk),
        .i_areset_n  (rst_n),
        .i_pll_locked(locked),
        .i_restart   (restart),
        .o_pll_areset(areset),
        .o_clkena    (clkena),
        .o_ready     (ready),
        .o_fault     (fault),
        .o_retries   (retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = PH_RST;
        m_entry   = 0;
        m_retries = 0;
        m_s0      = 1'b0;
        m_s1      = 1'b0;
        cyc       = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held through the cycle just ended
    task automatic model_step();
        int e;
        int nxt;
        bit rty;
        e   = cyc - m_entry;
        nxt = m_phase;
        rty = 1'b0;
        case (m_phase)
            PH_RST:  if (e + 1 >= RESET_CYCLES) nxt = PH_WAIT;
            PH_WAIT: if (m_s1) nxt = PH_FILT; else if (e + 1 >= LOCK_TIMEOUT) rty = 1'b1;
            PH_FILT: if (!m_s1) nxt = PH_WAIT; else if (e + 1 >= LOCK_CYCLES) nxt = PH_EN;
            PH_EN:   if (!m_s1) rty = 1'b1; else if (e >= (NCLK - 1) * ENA_STAGGER) nxt = PH_RUN;
            PH_RUN:  if (!m_s1) rty = 1'b1;
            default: nxt = m_phase;
        endcase
        if (rty) begin
            if (m_retries == MAX_RETRIES) nxt = PH_FAULT;
            else begin
                m_retries++;
                nxt = PH_RST;
            end
        end
        if (nxt == PH_RUN) m_retries = 0;
        if (restart) begin
            nxt       = PH_RST;
            m_retries = 0;
        end
        if ((nxt != m_phase) || rty || restart) m_entry = cyc + 1;
        m_phase = nxt;
        m_s1 = m_s0;
        m_s0 = locked;
    endtask

    task automatic check_model();
        int el;
        logic [NCLK-1:0] ek;
        el = cyc - m_entry;
        ek = '0;
        for (int k = 0; k < NCLK; k++) begin
            if (m_phase == PH_RUN || (m_phase == PH_EN && el >= k * ENA_STAGGER)) ek[k] = 1'b1;
        end
        check("m_areset",  32'(areset),  32'((m_phase == PH_RST || m_phase == PH_FAULT) ? 1 : 0));
        check("m_clkena",  32'(clkena),  32'(ek));
        check("m_ready",   32'(ready),   32'((m_phase == PH_RUN) ? 1 : 0));
        check("m_fault",   32'(fault),   32'((m_phase == PH_FAULT) ? 1 : 0));
        check("m_retries", 32'(retries), 32'(m_retries));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_areset"},  32'(areset),  32'(1));
        check({tag, "_clkena"},  32'(clkena),  32'(0));
        check({tag, "_ready"},   32'(ready),   32'(0));
        check({tag, "_fault"},   32'(fault),   32'(0));
        check({tag, "_retries"}, 32'(retries), 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        cyc++;
        check_model();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int seg_left;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        rst_n = 1'b1;
        model_reset();
        check_model();

        // Clean lock: lock rises in cycle 20 and holds
        run_to(7);  check("clean_areset_c7", 32'(areset), 32'(1));
        run_to(8);  check("clean_areset_c8", 32'(areset), 32'(0));
        run_to(20); locked = 1'b1;
        run_to(38); check("clean_clkena_c38", 32'(clkena), 32'(0));
        run_to(39); check("clean_clkena_c39", 32'(clkena), 32'(1));
        run_to(43); check("clean_clkena_c43", 32'(clkena), 32'(3));
        run_to(47); check("clean_clkena_c47", 32'(clkena), 32'(7));
                    check("clean_ready_c47",  32'(ready),  32'(0));
        run_to(48); check("clean_ready_c48",  32'(ready),  32'(1));

        // Lock loss in RUN, then relock
        run_to(60); locked = 1'b0;
        run_to(62); check("loss_ready_t2",   32'(ready),   32'(1));
        run_to(63); check("loss_clkena_t3",  32'(clkena),  32'(0));
                    check("loss_ready_t3",   32'(ready),   32'(0));
                    check("loss_areset_t3",  32'(areset),  32'(1));
                    check("loss_retries_t3", 32'(retries), 32'(1));
        locked = 1'b1;
        run_to(120); check("relock_ready",   32'(ready),   32'(1));
                     check("relock_retries", 32'(retries), 32'(0));

        // Glitchy lock: 5 high, 3 low, then steady from cycle 140
        locked  = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run_to(132); locked = 1'b1;
        run_to(137); locked = 1'b0;
        run_to(140); locked = 1'b1;
        run_to(151); check("glitch_clkena_c151", 32'(clkena), 32'(0));
        run_to(159); check("glitch_clkena_c159", 32'(clkena), 32'(1));
        run_to(167); check("glitch_ready_c167",  32'(ready),  32'(0));
        run_to(168); check("glitch_ready_c168",  32'(ready),  32'(1));

        // Timeout to fault with lock held low
        run_to(180);
        locked  = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run_to(252); check("to_areset_c252",  32'(areset),  32'(0));
                     check("to_retries_c252", 32'(retries), 32'(0));
        run_to(253); check("to_areset_c253",  32'(areset),  32'(1));
                     check("to_retries_c253", 32'(retries), 32'(1));
        run_to(260); check("to_areset_c260",  32'(areset),  32'(1));
        run_to(261); check("to_areset_c261",  32'(areset),  32'(0));
        run_to(325); check("to_retries_c325", 32'(retries), 32'(2));
        run_to(396); check("to_fault_c396",   32'(fault),   32'(0));
        run_to(397); check("to_fault_c397",   32'(fault),   32'(1));
                     check("to_areset_c397",  32'(areset),  32'(1));
        run_to(420); check("to_fault_hold",   32'(fault),   32'(1));

        // Restart from FAULT, then a clean lock relative to the restart
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check("rs_fault",   32'(fault),   32'(0));
        check("rs_retries", 32'(retries), 32'(0));
        check("rs_areset",  32'(areset),  32'(1));
        run_to(441); locked = 1'b1;
        run_to(460); check("rs_clkena_c460", 32'(clkena), 32'(1));
        run_to(468); check("rs_ready_c468",  32'(ready),  32'(0));
        run_to(469); check("rs_ready_c469",  32'(ready),  32'(1));

        // Asynchronous reset while two clocks are enabled
        run_to(480);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        run_to(511); check("ar_clkena_pre", 32'(clkena), 32'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("ar_async");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_vals("ar_held");
        rst_n = 1'b1;
        model_reset();
        check_model();

        // Randomized lock waveform with occasional restarts
        seg_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                locked   = ($urandom_range(0, 99) < 60);
                seg_left = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 150) : $urandom_range(1, 30);
            end else begin
                seg_left--;
            end
            restart = ($urandom_range(0, 299) == 0);
            tick();
        end
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
